stepdown_deadtime_seq: RTL
==========================

Name: stepdown_deadtime_seq

Overview:
- Break-before-make sequencer for the stepdown core-state high-side/low-side drive enables.
- Drives hs_en/ls_en toward the gate drivers.
- hs_fb/ls_fb are the drive states returned through the fixed 1ns delay cells; they are used to confirm turn-off.
- Inserts a programmable digital dead time and flags stuck or overlapping drives as faults.

Parameters:
- DT_W, 4, width of dead-time config (cycles).
- TO_CYCLES, 15, max cycles a turning-off side's feedback may stay high before fault.
- TO_W, 4, timeout counter width; must hold TO_CYCLES.

Ports:
- CELCLK, in, 1, core clock.
- CELRSTN, in, 1, asynchronous active-low reset.
- CELV / CELG / CELSUB, in, 1 each, supply/ground/substrate pass-through; no functional use.
- en, in, 1, sync; 1 = converter enabled.
- pwm, in, 1, sync; requested phase, 1 = high side, 0 = low side.
- dt_cfg, in, DT_W, dead time in cycles; 0 treated as 1.
- hs_fb, in, 1, async high-side feedback from delay cell.
- ls_fb, in, 1, async low-side feedback from delay cell.
- fault_clr, in, 1, sync pulse; clears FAULT.
- hs_en, out, 1, registered high-side enable.
- ls_en, out, 1, registered low-side enable.
- busy, out, 1, 1 in TOFF_HS, TOFF_LS, DEAD.
- fault, out, 1, 1 in FAULT.
- fault_code, out, 2, 00 none, 01 turn-off timeout, 10 shoot-through; held until cleared.

Behaviour:
- Reset (CELRSTN low, async): state OFF; hs_en=0, ls_en=0, busy=0, fault=0, fault_code=00; counters 0; feedback synchronizers 0.
- hs_fb/ls_fb pass through 2-flop synchronizers (hs_s/ls_s). All decisions use the synced values. 2-cycle sense latency.
- States: OFF, DEAD, HS_ON, LS_ON, TOFF_HS, TOFF_LS, FAULT.
- OFF: both en low. en=1 and hs_s=ls_s=0 -> DEAD.
- DEAD: on entry, load dcnt=max(dt_cfg,1); dt_cfg is sampled only at entry. Decrement each cycle. In the cycle dcnt==1:
  - en=0 -> OFF.
  - pwm=1 -> HS_ON, hs_en=1 next cycle.
  - pwm=0 -> LS_ON, ls_en=1 next cycle.
  - Dead time therefore = dt_cfg cycles of both-low after feedback confirmation.
- HS_ON: pwm=0 or en=0 -> TOFF_HS; hs_en=0 from the next cycle.
- LS_ON: mirror of HS_ON -> TOFF_LS.
- TOFF_x: tcnt increments while x_s=1.
  - x_s=0 -> DEAD; tcnt cleared.
  - tcnt reaches TO_CYCLES with x_s still 1 -> FAULT, code 01.
- pwm toggling during TOFF or DEAD: no abort. Sequence completes; the side is chosen from pwm at DEAD expiry. This may re-enable the same side, still after full dead time.
- en falling in any non-FAULT state: the active side goes through TOFF. An enable is never dropped and another raised in the same cycle.
- Shoot-through: hs_s=1 and ls_s=1 in any state -> FAULT, code 10. Priority over the timeout (same cycle -> 10).
- FAULT: hs_en=ls_en=0, busy=0, fault=1. fault_clr=1 with hs_s=ls_s=0 -> OFF, code 00 next cycle. fault_clr while feedback high is ignored.
- Invariant: hs_en and ls_en are never 1 in the same cycle. ls_en may rise only when hs_s=0, and vice versa.
- Counter widths saturate, no wrap. dcnt uses DT_W bits; tcnt uses TO_W bits.

Test Plan:
- Reset mid-DEAD (dt_cfg=5, assert CELRSTN low at dcnt=3) -> all outputs 0 immediately; state OFF after release.
- en=1, pwm=1, dt_cfg=3, feedback mirrors enables with 2-cycle delay -> hs_en rises exactly 3 cycles after DEAD entry; ls_en stays 0.
- HS_ON, pwm->0, dt_cfg=2 -> hs_en falls 1 cycle later. ls_en rises 2 cycles after hs_s falls. No cycle has both enables high.
- TOFF_HS with hs_fb held 1 -> fault=1, fault_code=01 after 15 cycles; hs_en=ls_en=0. fault_clr with hs_fb=1 ignored. hs_fb=0 then fault_clr -> OFF, code 00.
- Force hs_fb=ls_fb=1 in LS_ON -> FAULT code 10 two cycles after the overlap (sync latency).
- dt_cfg=0 -> dead time 1 cycle. pwm toggled 1->0->1 within TOFF_HS -> completes dead time, re-enters HS_ON.

Source files
------------

// File: rtl/stepdown_deadtime_seq.sv
// Break-before-make sequencer for the stepdown high-side/low-side drive enables.
// Inserts a programmable dead time after confirmed turn-off and traps stuck or
// overlapping drive feedback into a sticky fault state.
module stepdown_deadtime_seq #(
    parameter int unsigned DT_W      = 4,
    parameter int unsigned TO_CYCLES = 15,
    parameter int unsigned TO_W      = 4
) (
    input  logic            CELCLK,
    input  logic            CELRSTN,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            CELSUB,
    input  logic            en,
    input  logic            pwm,
    input  logic [DT_W-1:0] dt_cfg,
    input  logic            hs_fb,
    input  logic            ls_fb,
    input  logic            fault_clr,
    output logic            hs_en,
    output logic            ls_en,
    output logic            busy,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TO_CYCLES);
    localparam logic [1:0]      CODE_NONE  = 2'b00;
    localparam logic [1:0]      CODE_TOUT  = 2'b01;
    localparam logic [1:0]      CODE_SHOOT = 2'b10;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_DEAD,
        ST_HS_ON,
        ST_LS_ON,
        ST_TOFF_HS,
        ST_TOFF_LS,
        ST_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [DT_W-1:0] dcnt_q, dcnt_d;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic [1:0]      code_d;
    logic            hs_en_d, ls_en_d, busy_d, fault_d;
    logic            hs_m, ls_m, hs_s, ls_s;
    logic [DT_W-1:0] dt_load;
    logic [TO_W-1:0] tcnt_inc;
    logic            shoot;

    // Supply/ground/substrate pins exist only for the physical view.
    logic unused_supplies;
    assign unused_supplies = CELV ^ CELG ^ CELSUB;

    // A zero dead-time setting still guarantees one both-low cycle.
    assign dt_load  = (dt_cfg == '0) ? DT_W'(1) : dt_cfg;
    // Timeout counter saturates instead of wrapping.
    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TO_W'(1);
    assign shoot    = hs_s & ls_s;

    // Two-flop synchronizers for the asynchronous delay-cell feedback.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            hs_m <= 1'b0;
            ls_m <= 1'b0;
            hs_s <= 1'b0;
            ls_s <= 1'b0;
        end else begin
            hs_m <= hs_fb;
            ls_m <= ls_fb;
            hs_s <= hs_m;
            ls_s <= ls_m;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_q    <= ST_OFF;
            dcnt_q     <= '0;
            tcnt_q     <= '0;
            fault_code <= CODE_NONE;
            hs_en      <= 1'b0;
            ls_en      <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            tcnt_q     <= tcnt_d;
            fault_code <= code_d;
            hs_en      <= hs_en_d;
            ls_en      <= ls_en_d;
            busy       <= busy_d;
            fault      <= fault_d;
        end
    end

    // Next-state, counter and output decode; enables follow the next state so
    // only one side can ever be selected in a given cycle.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = '0;
        code_d  = fault_code;

        case (state_q)
            ST_OFF: begin
                if (en && !hs_s && !ls_s) begin
                    state_d = ST_DEAD;
                    dcnt_d  = dt_load;
                end
            end
            ST_DEAD: begin
                if (dcnt_q > DT_W'(1)) begin
                    dcnt_d = dcnt_q - DT_W'(1);
                end else if (!en) begin
                    state_d = ST_OFF;
                end else if (pwm && !ls_s) begin
                    state_d = ST_HS_ON;
                end else if (!pwm && !hs_s) begin
                    state_d = ST_LS_ON;
                end
            end
            ST_HS_ON: begin
                if (!pwm || !en) begin
                    state_d = ST_TOFF_HS;
                end
            end
            ST_LS_ON: begin
                if (pwm || !en) begin
                    state_d = ST_TOFF_LS;
                end
            end
            ST_TOFF_HS: begin
                if (!hs_s) begin
                    state_d = ST_DEAD;
                    dcnt_d  = dt_load;
                end else if (tcnt_inc >= TO_LIMIT) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_TOUT;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            ST_TOFF_LS: begin
                if (!ls_s) begin
                    state_d = ST_DEAD;
                    dcnt_d  = dt_load;
                end else if (tcnt_inc >= TO_LIMIT) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_TOUT;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !hs_s && !ls_s) begin
                    state_d = ST_OFF;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Overlapping feedback outranks every other transition, including a timeout.
        if (shoot && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
            code_d  = CODE_SHOOT;
            tcnt_d  = '0;
        end

        hs_en_d = (state_d == ST_HS_ON);
        ls_en_d = (state_d == ST_LS_ON);
        busy_d  = (state_d == ST_DEAD) || (state_d == ST_TOFF_HS) || (state_d == ST_TOFF_LS);
        fault_d = (state_d == ST_FAULT);
    end

endmodule
